// File: rtl/wb_pulse_gen.sv
// Wishbone-programmable multi-channel pulse/burst generator for calibration stimulus.
// Latency: bus ack one cycle after request; first active output one edge after the START commit edge.
// Backpressure: none; every access is acked one cycle after request, writes commit on that edge.
module wb_pulse_gen #(
   parameter int OUT_WIDTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [31:0]          wb_dat_i,
   output logic [31:0]          wb_dat_o,
   input  logic [31:0]          wb_adr_i,
   input  logic                 wb_we_i,
   input  logic [3:0]           wb_sel_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   output logic                 wb_ack_o,
   output logic [OUT_WIDTH-1:0] sig_out_o,
   output logic                 busy_o
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam logic [2:0] IDX_CTRL   = 3'd0;
   localparam logic [2:0] IDX_STATUS = 3'd1;
   localparam logic [2:0] IDX_PERIOD = 3'd2;
   localparam logic [2:0] IDX_WIDTH  = 3'd3;
   localparam logic [2:0] IDX_COUNT  = 3'd4;
   localparam logic [2:0] IDX_MASK   = 3'd5;
   localparam logic [2:0] IDX_IDLE   = 3'd6;

   // Programming registers
   logic                 cont_reg;
   logic [CNT_W-1:0]     period_reg;
   logic [CNT_W-1:0]     width_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [OUT_WIDTH-1:0] mask_reg;
   logic [OUT_WIDTH-1:0] idle_reg;
   logic                 done_reg;

   // Run-time shadows, frozen at START so later writes cannot disturb a run
   state_t               state;
   logic [CNT_W-1:0]     p_sh;
   logic [CNT_W-1:0]     width_sh;
   logic [CNT_W-1:0]     count_sh;
   logic [OUT_WIDTH-1:0] mask_sh;
   logic                 cont_sh;
   logic [CNT_W-1:0]     phase;
   logic [CNT_W-1:0]     pcnt;

   logic       acc;
   logic       wr;
   logic       rd;
   logic [2:0] idx;
   logic       start_req;
   logic       stop_req;
   logic       active;
   logic [31:0] rd_mux;
   logic       unused_adr_bits;

   // A new access is one not already being acked; this blocks back-to-back double acks
   assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr        = acc & wb_we_i;
   assign rd        = acc & ~wb_we_i;
   assign idx       = wb_adr_i[4:2];
   // STOP outranks START when both are set in the same write
   assign stop_req  = wr && (idx == IDX_CTRL) && wb_sel_i[0] && wb_dat_i[1];
   assign start_req = wr && (idx == IDX_CTRL) && wb_sel_i[0] && wb_dat_i[0] && !wb_dat_i[1];
   assign active    = (phase < width_sh);
   assign busy_o    = (state == ST_RUN);
   assign unused_adr_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

   // Byte-lane merge of write data into an existing register value
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
      end
      return r;
   endfunction

   // Read data selection; unmapped words and unused bits read as zero
   always_comb begin
      rd_mux = 32'd0;
      case (idx)
         IDX_CTRL:   rd_mux = {29'd0, cont_reg, 2'b00};
         IDX_STATUS: rd_mux = {30'd0, done_reg, busy_o};
         IDX_PERIOD: rd_mux = 32'(period_reg);
         IDX_WIDTH:  rd_mux = 32'(width_reg);
         IDX_COUNT:  rd_mux = 32'(count_reg);
         IDX_MASK:   rd_mux = 32'(mask_reg);
         IDX_IDLE:   rd_mux = 32'(idle_reg);
         default:    rd_mux = 32'd0;
      endcase
   end

   // Registered ack and read data
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'd0;
      end else begin
         wb_ack_o <= acc;
         wb_dat_o <= rd ? rd_mux : 32'd0;
      end
   end

   // Programming register writes, committed on the ack edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cont_reg   <= 1'b0;
         period_reg <= '0;
         width_reg  <= '0;
         count_reg  <= '0;
         mask_reg   <= '0;
         idle_reg   <= '0;
      end else if (wr) begin
         case (idx)
            IDX_CTRL:   if (wb_sel_i[0]) cont_reg <= wb_dat_i[2];
            IDX_PERIOD: period_reg <= CNT_W'(merge(32'(period_reg), wb_dat_i, wb_sel_i));
            IDX_WIDTH:  width_reg  <= CNT_W'(merge(32'(width_reg),  wb_dat_i, wb_sel_i));
            IDX_COUNT:  count_reg  <= CNT_W'(merge(32'(count_reg),  wb_dat_i, wb_sel_i));
            IDX_MASK:   mask_reg   <= OUT_WIDTH'(merge(32'(mask_reg), wb_dat_i, wb_sel_i));
            IDX_IDLE:   idle_reg   <= OUT_WIDTH'(merge(32'(idle_reg), wb_dat_i, wb_sel_i));
            default:    ;
         endcase
      end
   end

   // Run FSM, period/pulse counters, sticky done flag and registered drive vector
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         p_sh      <= '0;
         width_sh  <= '0;
         count_sh  <= '0;
         mask_sh   <= '0;
         cont_sh   <= 1'b0;
         phase     <= '0;
         pcnt      <= '0;
         done_reg  <= 1'b0;
         sig_out_o <= '0;
      end else begin
         // Idle level is always taken live; only the mask comes from the run shadow
         sig_out_o <= ((state == ST_RUN) && active) ? (idle_reg ^ mask_sh) : idle_reg;

         // Clear first so that a completion on the same edge wins
         if (wr && (idx == IDX_STATUS)) done_reg <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  p_sh     <= (period_reg < CNT_W'(2)) ? CNT_W'(2) : period_reg;
                  width_sh <= width_reg;
                  count_sh <= count_reg;
                  mask_sh  <= mask_reg;
                  cont_sh  <= wb_dat_i[2];
                  phase    <= '0;
                  pcnt     <= '0;
                  // A zero-length burst finishes immediately without entering RUN
                  if (!wb_dat_i[2] && (count_reg == '0)) done_reg <= 1'b1;
                  else                                   state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop_req) begin
                  state <= ST_IDLE;
               end else if (phase == p_sh - CNT_W'(1)) begin
                  phase <= '0;
                  pcnt  <= pcnt + CNT_W'(1);
                  if (!cont_sh && ((pcnt + CNT_W'(1)) == count_sh)) begin
                     state    <= ST_IDLE;
                     done_reg <= 1'b1;
                  end
               end else begin
                  phase <= phase + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_pulse_gen.sv
// Directed bench for wb_pulse_gen: register map, burst timing, continuous mode, stop and reset.
// Expected waveforms come from the period/width/count timing rule, indexed by edges after START.
// Bus accesses are single-beat with a bounded wait on ack.
module tb_wb_pulse_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic [31:0] adr = '0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        ack;
   logic [7:0]  sig;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;
   logic [31:0] rdat;
   int e;

   wb_pulse_gen #(.OUT_WIDTH(8), .CNT_W(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
      .wb_adr_i(adr), .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc), .wb_stb_i(stb),
      .wb_ack_o(ack), .sig_out_o(sig), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
      int n;
      adr = {27'd0, i, 2'b00}; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin step(); n++; end while (ack !== 1'b1 && n < 16);
      check("wr_ack", {31'd0, ack}, 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
   endtask

   task automatic wb_read(input logic [2:0] i, output logic [31:0] d);
      int n;
      adr = {27'd0, i, 2'b00}; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      n = 0;
      do begin step(); n++; end while (ack !== 1'b1 && n < 16);
      check("rd_ack", {31'd0, ack}, 32'd1);
      d = dat_o;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] i, input logic [31:0] exp);
      logic [31:0] d;
      wb_read(i, d);
      check(tag, d, exp);
   endtask

   // Step to edge e+kmax, checking output and busy after every edge from the current one
   task automatic run_check(input string tag, input int e0, input int kmax, input int per,
                            input int wid, input int cnt, input logic [7:0] on_v,
                            input logic [7:0] off_v);
      int k;
      logic [7:0] x;
      while (cyc_cnt - e0 < kmax) begin
         step();
         k = cyc_cnt - e0;
         x = (k >= 1 && k <= per * cnt && ((k - 1) % per) < wid) ? on_v : off_v;
         check({tag, "_sig"}, {24'd0, sig}, {24'd0, x});
         check({tag, "_busy"}, {31'd0, busy}, (k < per * cnt) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      // 1: reset held with an access pending
      rst = 1'b1; cyc = 1'b1; stb = 1'b1; adr = 32'd8;
      repeat (3) step();
      check("rst_ack",  {31'd0, ack},  32'd0);
      check("rst_sig",  {24'd0, sig},  32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_dat",  dat_o,         32'd0);
      cyc = 1'b0; stb = 1'b0;
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < 7; i++) rd_chk("rst_reg", 3'(i), 32'd0);

      // 2: four pulses of 0x05, 3 high / 7 low
      wb_write(3'd2, 32'd10, 4'hF);
      wb_write(3'd3, 32'd3, 4'hF);
      wb_write(3'd4, 32'd4, 4'hF);
      wb_write(3'd5, 32'h05, 4'hF);
      wb_write(3'd6, 32'h00, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      e = cyc_cnt;
      check("t2_sig_e", {24'd0, sig}, 32'd0);
      run_check("t2", e, 44, 10, 3, 4, 8'h05, 8'h00);
      rd_chk("t2_status", 3'd1, 32'd2);
      wb_write(3'd1, 32'd0, 4'hF);
      rd_chk("t2_status_clr", 3'd1, 32'd0);

      // 3: continuous, period clamped to 2, then STOP
      wb_write(3'd6, 32'hFF, 4'hF);
      wb_write(3'd5, 32'h0F, 4'hF);
      wb_write(3'd2, 32'd1, 4'hF);
      wb_write(3'd3, 32'd1, 4'hF);
      wb_write(3'd0, 32'h5, 4'hF);
      e = cyc_cnt;
      run_check("t3", e, 6, 2, 1, 1000, 8'hF0, 8'hFF);
      rd_chk("t3_ctrl", 3'd0, 32'h4);
      wb_write(3'd0, 32'h2, 4'hF);
      step();
      check("t3_stop_sig",  {24'd0, sig},  32'hFF);
      check("t3_stop_busy", {31'd0, busy}, 32'd0);
      step();
      check("t3_stop_sig2", {24'd0, sig},  32'hFF);
      rd_chk("t3_status", 3'd1, 32'd0);

      // 4a: COUNT=0 finishes at once with no pulse
      wb_write(3'd6, 32'h00, 4'hF);
      wb_write(3'd4, 32'd0, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      check("t4_busy0", {31'd0, busy}, 32'd0);
      step();
      check("t4_sig0", {24'd0, sig}, 32'd0);
      rd_chk("t4_status0", 3'd1, 32'd2);
      wb_write(3'd1, 32'd0, 4'hF);
      // 4b: WIDTH=0, COUNT=2, P=4 -> no pulse, done after 8 cycles
      wb_write(3'd3, 32'd0, 4'hF);
      wb_write(3'd4, 32'd2, 4'hF);
      wb_write(3'd2, 32'd4, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      e = cyc_cnt;
      run_check("t4b", e, 9, 4, 0, 2, 8'h0F, 8'h00);
      rd_chk("t4_status1", 3'd1, 32'd2);
      wb_write(3'd1, 32'd0, 4'hF);

      // 5: run isolation from mid-run writes, byte-lane writes, unmapped word
      wb_write(3'd2, 32'd6, 4'hF);
      wb_write(3'd3, 32'd2, 4'hF);
      wb_write(3'd5, 32'h30, 4'hF);
      wb_write(3'd6, 32'h01, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      e = cyc_cnt;
      wb_write(3'd2, 32'd3, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      run_check("t5", e, 14, 6, 2, 2, 8'h31, 8'h01);
      rd_chk("t5_status", 3'd1, 32'd2);
      rd_chk("t5_period", 3'd2, 32'd3);
      wb_write(3'd2, 32'h0000ABCD, 4'b0001);
      rd_chk("t5_sel", 3'd2, 32'h000000CD);
      wb_write(3'd7, 32'hFFFFFFFF, 4'hF);
      rd_chk("t5_unmapped", 3'd7, 32'd0);

      // 6: reset in the middle of a pulse with an access in flight
      wb_write(3'd2, 32'd10, 4'hF);
      wb_write(3'd3, 32'd5, 4'hF);
      wb_write(3'd4, 32'd3, 4'hF);
      wb_write(3'd5, 32'hFF, 4'hF);
      wb_write(3'd6, 32'h00, 4'hF);
      wb_write(3'd0, 32'h1, 4'hF);
      step();
      step();
      check("t6_pre_sig", {24'd0, sig}, 32'hFF);
      adr = 32'd8; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
      step();
      check("t6_sig",  {24'd0, sig},  32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_ack",  {31'd0, ack},  32'd0);
      cyc = 1'b0; stb = 1'b0; rst = 1'b0;
      step();
      check("t6_ack2", {31'd0, ack}, 32'd0);
      rd_chk("t6_period", 3'd2, 32'd0);
      rd_chk("t6_status", 3'd1, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
